// File: rtl/muldiv_seq.sv
// Iterative MUL/SMUL/UMUL/DIV unit: one bit per cycle, WIDTH cycles per op.
// Shift-add multiply and restoring divide share one {hi,lo} working register.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Long,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UMUL = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] bop_q, bop_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] long_q, long_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   drem, ddiff;
  logic             dge;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Multiply: add multiplicand when the current multiplier bit is set, shift right.
  assign msum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? bop_q : {WIDTH{1'b0}})};
  // Divide: shift dividend MSB into remainder, subtract divisor if it fits.
  assign drem  = {hi_q, lo_q[WIDTH-1]};
  assign ddiff = drem - {1'b0, bop_q};
  assign dge   = (drem >= {1'b0, bop_q});

  always_comb begin
    hi_nx = hi_q;
    lo_nx = lo_q;
    if (op_q == OP_DIV) begin
      hi_nx = dge ? ddiff[WIDTH-1:0] : drem[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], dge};
    end else begin
      hi_nx = msum[WIDTH:1];
      lo_nx = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign prod     = {hi_nx, lo_nx};
  assign prod_neg = ~prod + 1'b1;
  assign accept   = Start && ALUControl[2] && (state_q != S_CALC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bop_d   = bop_q;
    res_d   = res_q;
    long_d  = long_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = CW'(WIDTH);
          op_d    = ALUControl[1:0];
          hi_d    = '0;
          dbz_d   = 1'b0;
          if (ALUControl[1:0] == OP_SMUL) begin
            lo_d   = a_mag;
            bop_d  = b_mag;
            sign_d = a[WIDTH-1] ^ b[WIDTH-1];
          end else begin
            lo_d   = a;
            bop_d  = b;
            sign_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_UMUL: {long_d, res_d} = prod;
            OP_SMUL: {long_d, res_d} = sign_q ? prod_neg : prod;
            OP_DIV: begin
              res_d  = lo_nx;
              long_d = '0;
              dbz_d  = (bop_q == '0);
            end
            default: begin
              res_d  = lo_nx;
              long_d = '0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      bop_q   <= '0;
      res_q   <= '0;
      long_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bop_q   <= bop_d;
      res_q   <= res_d;
      long_q  <= long_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Result    = res_q;
  assign Long      = long_q;
  assign DivByZero = dbz_q;
  assign Busy      = (state_q == S_CALC);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: expected results are queued at issue time
// and a negedge monitor compares them (value and cycle) whenever Done pulses.
module tb_muldiv_seq;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             Start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] Result, Long;
  logic             Busy, Done, DivByZero;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
    .a(a), .b(b), .Result(Result), .Long(Long),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] lng;
    logic             dbz;
    int               at;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(Done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(Result), 64'(e.res));
        chk("long", 64'(Long), 64'(e.lng));
        chk("divbyzero", 64'(DivByZero), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at a negedge; Start is sampled at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input bit push, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] l,
                       input logic z);
    Start = 1'b1; ALUControl = op; a = av; b = bv;
    @(posedge clk); #1;
    if (push) sb.push_back('{res: r, lng: l, dbz: z, at: cyc + WIDTH});
    Start = 1'b0;
    a = $urandom; b = $urandom; ALUControl = 3'($urandom);
    @(negedge clk);
    chk("busy_after_start", 64'(Busy), 64'(1));
    chk("dbz_cleared", 64'(DivByZero), 64'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Done) chk("done_timeout", 64'(Done), 64'(1));
  endtask

  task automatic run(input logic [2:0] op, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] l, input logic z);
    issue(op, av, bv, 1'b1, r, l, z);
    wait_done();
    @(negedge clk);
    chk("done_one_cycle", 64'(Done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    chk("rst_long", 64'(Long), 64'(0));
    chk("rst_dbz", 64'(DivByZero), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run(3'b100, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    run(3'b101, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    run(3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0);
    run(3'b101, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

    // UMUL then DIV issued in the UMUL Done cycle.
    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    wait_done();
    run(3'b111, 32'd100, 32'd7, 32'd14, 32'd0, 1'b0);

    run(3'b111, 32'd7, 32'd100, 32'd0, 32'd0, 1'b0);
    run(3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Divide by zero: flag and result held until the next accepted Start.
    run(3'b111, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    repeat (5) @(negedge clk);
    chk("dbz_held", 64'(DivByZero), 64'(1));
    chk("dbz_result_held", 64'(Result), 64'hFFFF_FFFF);
    run(3'b100, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0);

    // Reset mid-CALC with an ignored Start in between.
    issue(3'b100, 32'd3, 32'd4, 1'b0, '0, '0, 1'b0);
    repeat (8) @(negedge clk);
    Start = 1'b1; ALUControl = 3'b111; a = 32'd9; b = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    chk("busy_ignores_start", 64'(Busy), 64'(1));
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(Busy), 64'(0));
    chk("midrst_done", 64'(Done), 64'(0));
    chk("midrst_result", 64'(Result), 64'(0));
    chk("midrst_long", 64'(Long), 64'(0));
    chk("midrst_dbz", 64'(DivByZero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", 64'(Busy), 64'(0));
    run(3'b100, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);

    // Single-cycle op code is not accepted.
    Start = 1'b1; ALUControl = 3'b010; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("alu_op_no_busy", 64'(Busy), 64'(0));
    repeat (40) @(negedge clk);
    chk("alu_op_result_kept", 64'(Result), 64'(12));
    chk("alu_op_long_kept", 64'(Long), 64'(0));

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for the long-latency ALU operations: MUL, SMUL, UMUL and DIV (ALUControl 100/101/110/111). It computes them iteratively, one bit per cycle, so they no longer sit in the single-cycle critical path. The control unit issues a Start pulse and stalls the pipeline while Busy is high. It captures Result and Long when Done pulses. Single-cycle ops (ADD/SUB/AND/ORR) stay in the combinational ALU and are ignored here.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE or DONE
ALUControl  input  3  operation select; captured with Start
a  input  WIDTH  operand A / dividend; captured with Start
b  input  WIDTH  operand B / divisor; captured with Start
Result  output  WIDTH  low product word or quotient
Long  output  WIDTH  high product word for SMUL/UMUL; 0 for MUL and DIV
Busy  output  1  high while iterating; the pipeline must stall
Done  output  1  one-cycle pulse; Result/Long valid from this cycle
DivByZero  output  1  set with Done when DIV had b == 0

Behaviour:
- States: IDLE, CALC, DONE. Reset puts the FSM in IDLE and clears the counter, Result, Long, Busy, Done, DivByZero and all internal operand registers to 0.
- Reset wins over every other event, including mid-CALC. The in-flight op is discarded and no Done is issued.
- IDLE or DONE with Start = 1 and ALUControl[2] = 1: latch a, b and op, clear DivByZero, load counter = WIDTH, go to CALC.
- IDLE or DONE with Start = 1 and ALUControl[2] = 0: ignored; the FSM stays put, or DONE→IDLE.
- DONE without an accepted Start: go to IDLE.
- Busy = (state == CALC). Done = (state == DONE).
- Start while Busy is ignored. Input changes during CALC have no effect.
- CALC lasts exactly WIDTH cycles; the counter decrements each cycle and the FSM moves to DONE when the counter reaches 1.
- Latency: Start sampled at edge k → Busy high for cycles k+1 … k+WIDTH → Done high in cycle k+WIDTH+1.
- Back-to-back: Start accepted in the DONE cycle re-enters CALC next cycle.
- Result, Long and DivByZero hold their values after DONE until the next accepted Start or reset. They are not cleared on DONE→IDLE.
- MUL / UMUL: unsigned shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
  - UMUL: {Long, Result} = a × b (unsigned).
  - MUL: Result = low WIDTH bits; Long = 0.
- SMUL:
  - Take the two's-complement magnitudes of a and b at Start and record sign = a[MSB] ^ b[MSB].
  - Multiply unsigned; if sign = 1, negate the full 2·WIDTH product in the DONE transition.
  - The most negative operand (0x80000000) must work: its magnitude is 2^31, handled unsigned.
- DIV: unsigned restoring division, one quotient bit per cycle.
  - Result = floor(a / b); Long = 0.
  - b == 0: full WIDTH-cycle latency is kept, Result = all ones, Long = 0, DivByZero = 1 in the Done cycle and held.
- No flags are produced. The control unit does not update NZCV for these ops.

Test Plan:
- MUL a=7, b=6: Start at cycle 0 → Busy cycles 1–32, Done at cycle 33, Result=42, Long=0, DivByZero=0.
- SMUL a=0xFFFFFFFD (−3), b=5 → Long=0xFFFFFFFF, Result=0xFFFFFFF1. Also a=0x80000000, b=0x80000000 → Long=0x40000000, Result=0x00000000.
- UMUL a=0xFFFFFFFF, b=0xFFFFFFFF → Long=0xFFFFFFFE, Result=0x00000001. Then DIV a=100, b=7 started in that Done cycle → Busy next cycle, Done 33 cycles after its Start, Result=14, Long=0.
- DIV a=5, b=0 → Done after 33 cycles, Result=0xFFFFFFFF, Long=0, DivByZero=1. DivByZero stays 1 until the next accepted Start.
- Start MUL a=3, b=4; pulse Start with a=9, b=9, op=111 at cycle 10 (ignored); assert reset at cycle 20 → Busy=0 and all outputs 0 at cycle 21, no Done pulse. A fresh MUL 3×4 afterwards → Result=12.
- Start with ALUControl=010 in IDLE → no Busy, no Done; outputs unchanged.
